// File: rtl/ramb_tdp_asym.sv
`default_nettype none
// ============================================================================
//  Module      : ramb_tdp_asym
//  Description : Single-clock true-dual-port block RAM. Ports A and B use
//                independent power-of-two widths over one shared bit array.
//                Each port has its own write mode. An optional output pipeline
//                stage, reset values and a registered collision flag are
//                provided.
//  Revision    : 1.0 - initial release
// ============================================================================
module ramb_tdp_asym #(
    parameter int                      TOTAL_BITS   = 4096,
    parameter int                      WIDTH_A      = 1,
    parameter int                      WIDTH_B      = 2,
    parameter string                   WRITE_MODE_A = "WRITE_FIRST",
    parameter string                   WRITE_MODE_B = "WRITE_FIRST",
    parameter int                      DO_REG       = 0,
    parameter logic [WIDTH_A-1:0]      SRVAL_A      = '0,
    parameter logic [WIDTH_B-1:0]      SRVAL_B      = '0,
    parameter logic [TOTAL_BITS-1:0]   INIT         = '0,
    localparam int                     AWA          = $clog2(TOTAL_BITS / WIDTH_A),
    localparam int                     AWB          = $clog2(TOTAL_BITS / WIDTH_B)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENA,
    input  logic               WEA,
    input  logic [AWA-1:0]     ADDRA,
    input  logic [WIDTH_A-1:0] DIA,
    output logic [WIDTH_A-1:0] DOA,
    input  logic               ENB,
    input  logic               WEB,
    input  logic [AWB-1:0]     ADDRB,
    input  logic [WIDTH_B-1:0] DIB,
    output logic [WIDTH_B-1:0] DOB,
    output logic               COLL
);

    // Ratio of B width to A width and its log2 (A address bits below B address)
    localparam int c_R  = WIDTH_B / WIDTH_A;
    localparam int c_RB = $clog2(c_R);

    // Write-mode encodings
    localparam logic [1:0] c_WRITE_FIRST = 2'd0;
    localparam logic [1:0] c_READ_FIRST  = 2'd1;
    localparam logic [1:0] c_NO_CHANGE   = 2'd2;
    localparam logic [1:0] c_BAD_MODE    = 2'd3;

    localparam logic [1:0] c_MODE_A =
        (WRITE_MODE_A == "WRITE_FIRST") ? c_WRITE_FIRST :
        (WRITE_MODE_A == "READ_FIRST")  ? c_READ_FIRST  :
        (WRITE_MODE_A == "NO_CHANGE")   ? c_NO_CHANGE   : c_BAD_MODE;
    localparam logic [1:0] c_MODE_B =
        (WRITE_MODE_B == "WRITE_FIRST") ? c_WRITE_FIRST :
        (WRITE_MODE_B == "READ_FIRST")  ? c_READ_FIRST  :
        (WRITE_MODE_B == "NO_CHANGE")   ? c_NO_CHANGE   : c_BAD_MODE;

    // ------------------------------------------------------------------------
    // Elaboration-time legality checks
    // ------------------------------------------------------------------------
    if ((WIDTH_A <= 0) || ((WIDTH_A & (WIDTH_A - 1)) != 0)) begin : g_err_width_a
        $error("ramb_tdp_asym: WIDTH_A must be a power of two");
    end
    if ((WIDTH_B < WIDTH_A) || ((WIDTH_B % WIDTH_A) != 0) || ((c_R & (c_R - 1)) != 0)) begin : g_err_ratio
        $error("ramb_tdp_asym: WIDTH_B must be a power-of-two multiple of WIDTH_A");
    end
    if ((TOTAL_BITS % WIDTH_B) != 0) begin : g_err_total
        $error("ramb_tdp_asym: TOTAL_BITS must be divisible by WIDTH_B");
    end
    if (c_MODE_A == c_BAD_MODE) begin : g_err_mode_a
        $error("ramb_tdp_asym: illegal WRITE_MODE_A");
    end
    if (c_MODE_B == c_BAD_MODE) begin : g_err_mode_b
        $error("ramb_tdp_asym: illegal WRITE_MODE_B");
    end

    // ------------------------------------------------------------------------
    // Shared bit array, loaded with INIT at power-up
    // ------------------------------------------------------------------------
    logic [TOTAL_BITS-1:0] mem_q = INIT;

    logic [WIDTH_A-1:0] rd_a;
    logic [WIDTH_B-1:0] rd_b;
    logic [WIDTH_A-1:0] doa1_q, doa1_d;
    logic [WIDTH_B-1:0] dob1_q, dob1_d;
    logic               coll_q, coll_d;

    // Array read taps: always the pre-edge contents, so no cross-port forwarding
    always_comb begin
        rd_a = mem_q[ADDRA * WIDTH_A +: WIDTH_A];
        rd_b = mem_q[ADDRB * WIDTH_B +: WIDTH_B];
    end

    // Array update: B is written last so it wins on overlapping bits; RST blocks writes
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (ENA && WEA) begin
                mem_q[ADDRA * WIDTH_A +: WIDTH_A] <= DIA;
            end
            if (ENB && WEB) begin
                mem_q[ADDRB * WIDTH_B +: WIDTH_B] <= DIB;
            end
        end
    end

    // Port A first-stage next value according to enable, write and write mode
    always_comb begin
        doa1_d = doa1_q;
        if (ENA) begin
            if (!WEA) begin
                doa1_d = rd_a;
            end else begin
                case (c_MODE_A)
                    c_WRITE_FIRST: doa1_d = DIA;
                    c_READ_FIRST:  doa1_d = rd_a;
                    default:       doa1_d = doa1_q;
                endcase
            end
        end
    end

    // Port B first-stage next value according to enable, write and write mode
    always_comb begin
        dob1_d = dob1_q;
        if (ENB) begin
            if (!WEB) begin
                dob1_d = rd_b;
            end else begin
                case (c_MODE_B)
                    c_WRITE_FIRST: dob1_d = DIB;
                    c_READ_FIRST:  dob1_d = rd_b;
                    default:       dob1_d = dob1_q;
                endcase
            end
        end
    end

    // Overlap: both enabled, at least one writing, A word lies inside the B word
    always_comb begin
        coll_d = ENA && ENB && (WEA || WEB) && (ADDRA[AWA-1:c_RB] == ADDRB);
    end

    // First output stage and collision flag; reset overrides enables
    always_ff @(posedge CLK) begin
        if (RST) begin
            doa1_q <= SRVAL_A;
            dob1_q <= SRVAL_B;
            coll_q <= 1'b0;
        end else begin
            doa1_q <= doa1_d;
            dob1_q <= dob1_d;
            coll_q <= coll_d;
        end
    end

    assign COLL = coll_q;

    // ------------------------------------------------------------------------
    // Optional output pipeline stage
    // ------------------------------------------------------------------------
    if (DO_REG == 1) begin : g_doreg
        logic [WIDTH_A-1:0] doa2_q;
        logic [WIDTH_B-1:0] dob2_q;

        // Second stage loads the first stage every cycle; reset drops reads in flight
        always_ff @(posedge CLK) begin
            if (RST) begin
                doa2_q <= SRVAL_A;
                dob2_q <= SRVAL_B;
            end else begin
                doa2_q <= doa1_q;
                dob2_q <= dob1_q;
            end
        end

        assign DOA = doa2_q;
        assign DOB = dob2_q;
    end else begin : g_nodoreg
        assign DOA = doa1_q;
        assign DOB = dob1_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ramb_tdp_asym.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ramb_tdp_asym
//  Description : Bench for ramb_tdp_asym. Three instances with different
//                write modes and output latency share one stimulus stream
//                and are compared against a bit-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ramb_tdp_asym;

    localparam int          c_TOTAL = 64;
    localparam logic [63:0] c_INIT  = 64'hA5C3_0F1E_9D27_6B4A;
    localparam logic        c_SRA   = 1'b1;
    localparam logic [1:0]  c_SRB   = 2'b10;

    // Per-instance configuration: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE
    int c_ma[3] = '{0, 1, 2};
    int c_mb[3] = '{0, 2, 1};
    int c_dr[3] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst, ena, wea, enb, web;
    logic [5:0] addra;
    logic [4:0] addrb;
    logic       dia;
    logic [1:0] dib;
    logic [2:0] doa_w;
    logic [5:0] dob_w;
    logic [2:0] coll_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ramb_tdp_asym #(
        .TOTAL_BITS(c_TOTAL), .WIDTH_A(1), .WIDTH_B(2),
        .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"), .DO_REG(0),
        .SRVAL_A(c_SRA), .SRVAL_B(c_SRB), .INIT(c_INIT)
    ) u0 (
        .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa_w[0]),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob_w[1:0]), .COLL(coll_w[0])
    );

    ramb_tdp_asym #(
        .TOTAL_BITS(c_TOTAL), .WIDTH_A(1), .WIDTH_B(2),
        .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"), .DO_REG(1),
        .SRVAL_A(c_SRA), .SRVAL_B(c_SRB), .INIT(c_INIT)
    ) u1 (
        .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa_w[1]),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob_w[3:2]), .COLL(coll_w[1])
    );

    ramb_tdp_asym #(
        .TOTAL_BITS(c_TOTAL), .WIDTH_A(1), .WIDTH_B(2),
        .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"), .DO_REG(0),
        .SRVAL_A(c_SRA), .SRVAL_B(c_SRB), .INIT(c_INIT)
    ) u2 (
        .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa_w[2]),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob_w[5:4]), .COLL(coll_w[2])
    );

    // Reference model: plain bit array plus the value each output register holds
    logic [63:0] m_mem;
    logic [1:0]  m_a1[3], m_a2[3], m_b1[3], m_b2[3];
    logic        m_coll;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // What a port shows after an edge, from the write-mode rules
    function automatic logic [1:0] port_next(input int mode, input logic en, input logic we,
                                             input logic [1:0] prev, input logic [1:0] rd,
                                             input logic [1:0] di);
        if (!en)       return prev;
        if (!we)       return rd;
        if (mode == 0) return di;
        if (mode == 1) return rd;
        return prev;
    endfunction

    // One clock cycle: drive, advance model at the edge, then compare all outputs
    task automatic cyc(input logic r, input logic ea, input logic wa, input logic [5:0] aa,
                       input logic da, input logic eb, input logic wb, input logic [4:0] ab,
                       input logic [1:0] db);
        logic [1:0] rda, rdb;
        @(negedge clk);
        rst = r; ena = ea; wea = wa; addra = aa; dia = da;
        enb = eb; web = wb; addrb = ab; dib = db;
        @(posedge clk);
        rda = {1'b0, m_mem[aa]};
        rdb = m_mem[ab * 2 +: 2];
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_a1[i] = {1'b0, c_SRA}; m_a2[i] = {1'b0, c_SRA};
                m_b1[i] = c_SRB;         m_b2[i] = c_SRB;
            end
            m_coll = 1'b0;
        end else begin
            m_coll = ea && eb && (wa || wb) && ((aa / 2) == ab);
            for (int i = 0; i < 3; i++) begin
                m_a2[i] = m_a1[i];
                m_b2[i] = m_b1[i];
                m_a1[i] = port_next(c_ma[i], ea, wa, m_a1[i], rda, {1'b0, da});
                m_b1[i] = port_next(c_mb[i], eb, wb, m_b1[i], rdb, db);
            end
            if (ea && wa) m_mem[aa] = da;
            if (eb && wb) m_mem[ab * 2 +: 2] = db;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("doa_u%0d", i), {31'd0, doa_w[i]},
                     {31'd0, (c_dr[i] == 1) ? m_a2[i][0] : m_a1[i][0]});
            check_eq($sformatf("dob_u%0d", i), {30'd0, dob_w[i*2 +: 2]},
                     {30'd0, (c_dr[i] == 1) ? m_b2[i] : m_b1[i]});
            check_eq($sformatf("coll_u%0d", i), {31'd0, coll_w[i]}, {31'd0, m_coll});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    endtask

    initial begin
        logic [31:0] rv;
        logic [4:0]  rb;
        logic [5:0]  ra;
        m_mem = c_INIT;
        rst = 1'b1; ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
        addra = '0; addrb = '0; dia = 1'b0; dib = '0;

        // Reset for two cycles, then read INIT through B
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0);
        idle(2);

        // Width aliasing: A words 6,7 form B word 3
        cyc(1'b0, 1'b1, 1'b1, 6'd6, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
        cyc(1'b0, 1'b1, 1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 5'd3, 2'd0);
        idle(2);

        // Write modes on B at addr 5: preload 11, read it, then write 00
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 5'd5, 2'b11);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 5'd5, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 5'd5, 2'b00);
        idle(2);

        // Write-write collision at B word 0, then a non-overlapping pair
        cyc(1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 1'b1, 5'd0, 2'b10);
        cyc(1'b0, 1'b1, 1'b0, 6'd2, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00);
        idle(2);

        // Write-read collision: clear word 0, A writes bit 1 while B reads
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 5'd0, 2'b00);
        cyc(1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 1'b0, 5'd0, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00);
        idle(2);

        // Back-to-back overlaps keep COLL high
        cyc(1'b0, 1'b1, 1'b1, 6'd9, 1'b0, 1'b1, 1'b0, 5'd4, 2'b00);
        cyc(1'b0, 1'b1, 1'b0, 6'd8, 1'b0, 1'b1, 1'b1, 5'd4, 2'b01);
        idle(2);

        // Enable gating: WEA without ENA changes nothing
        cyc(1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
        idle(2);

        // Reset priority: write under RST is discarded
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 5'd4, 2'b11);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 5'd4, 2'b00);
        idle(2);

        // Random traffic, biased towards overlapping addresses
        for (int n = 0; n < 3000; n++) begin
            rv = $urandom;
            rb = rv[4:0];
            ra = rv[5] ? {rb, rv[6]} : rv[12:7];
            cyc(rv[18:13] == 6'd0, rv[19] | rv[20], rv[21], ra, rv[22],
                rv[23] | rv[24], rv[25], rb, rv[27:26]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
